// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multi-cycle RV32I main controller:
// state encodings, opcode values, ALUOp codes, mux select codes, and the
// per-state control decode used by the FSM.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12,
    S_JALR     = 4'd13,
    S_JALRWB   = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_ITYPE  = 3'b011;
  localparam logic [2:0] ALU_BRANCH = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       trap;
  } ctl_t;

  // Pure Moore decode: everything not set here is 0 / 00 / ADD.
  function automatic ctl_t state_ctl(input logic [3:0] st);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH:    begin c.ir_write = 1'b1; c.pc_update = 1'b1;
                        c.src_a = SRCA_PC; c.src_b = SRCB_FOUR; c.result_src = RES_ALURES; end
      S_DECODE:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_MEMADR:   begin c.src_a = SRCA_REG; c.src_b = SRCB_IMM; end
      S_MEMREAD:  begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; c.retire = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; c.mem_write = 1'b1;
                        c.retire = 1'b1; end
      S_EXECR:    begin c.src_a = SRCA_REG; c.src_b = SRCB_REG; c.alu_op = ALU_RTYPE; end
      S_EXECI:    begin c.src_a = SRCA_REG; c.src_b = SRCB_IMM; c.alu_op = ALU_ITYPE; end
      S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; c.retire = 1'b1; end
      S_JAL:      begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR; c.result_src = RES_ALUOUT;
                        c.pc_update = 1'b1; end
      S_BRANCH:   begin c.src_a = SRCA_REG; c.src_b = SRCB_REG; c.alu_op = ALU_BRANCH;
                        c.result_src = RES_ALUOUT; c.branch = 1'b1; c.retire = 1'b1; end
      S_LUI:      begin c.result_src = RES_IMM; c.reg_write = 1'b1; c.retire = 1'b1; end
      S_AUIPC:    begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_JALR:     begin c.src_a = SRCA_REG; c.src_b = SRCB_IMM; c.result_src = RES_ALURES;
                        c.pc_update = 1'b1; end
      S_JALRWB:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR; c.result_src = RES_ALURES;
                        c.reg_write = 1'b1; c.retire = 1'b1; end
      S_TRAP:     c.trap = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle. master = the controller, slave = the
// datapath side that supplies the opcode/mem_ready and consumes controls.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCUpdate;
  logic             RegWrite;
  logic             MemWrite;
  logic             Branch;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic [1:0]       ResultSrc;
  logic [3:0]       FSMState;
  logic             instr_retired;
  logic             illegal_instr;
  logic [CNT_W-1:0] retire_count;

  modport master (
    input  opcode, mem_ready,
    output AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, FSMState,
           instr_retired, illegal_instr, retire_count
  );

  modport slave (
    output opcode, mem_ready,
    input  AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, FSMState,
           instr_retired, illegal_instr, retire_count
  );
endinterface

// File: rtl/control_fsm_retire_ctr.sv
// Retired-instruction counter: wraps modulo 2^W, async active-low clear.
module control_fsm_retire_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  // Count one per retire pulse; natural overflow gives the wrap to 0.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)   count <= '0;
    else if (inc) count <= count + W'(1);
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multi-cycle RV32I datapath (Moore FSM).
// Optional build macro CONTROL_FSM_MEM_STALL_EN: FETCH/MEMREAD/MEMWRITE hold
// until mem_ready, with IRWrite/PCUpdate/MemWrite and the MEMWRITE retire
// only in the completing cycle. Without it mem_ready is ignored.
module multicycle_control_fsm
  import control_fsm_pkg::*;
#(
  parameter int RETIRE_CNT_W = 32,
  parameter bit TRAP_HALT    = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_control_fsm_if.master bus
);

  logic [3:0] state, state_nxt;
  logic       mem_ok;
  logic       hold;
  ctl_t       ctl, ctl_out;

`ifdef CONTROL_FSM_MEM_STALL_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // A memory-touching state waits while memory has not completed.
  assign hold = !mem_ok && (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE);

  // Next-state selection; DECODE dispatches on the opcode field.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_JAL:            state_nxt = S_JAL;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          OP_JALR:           state_nxt = S_JALR;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_BRANCH:   state_nxt = S_FETCH;
      S_LUI:      state_nxt = S_FETCH;
      S_AUIPC:    state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_JALRWB;
      S_JALRWB:   state_nxt = S_FETCH;
      S_TRAP:     state_nxt = TRAP_HALT ? S_TRAP : S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
    if (hold) state_nxt = state;
  end

  // State register; reset lands in FETCH so the first edge after release fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  assign ctl = state_ctl(state);

  // Enables are gated combinationally so they drop the instant reset falls,
  // and are suppressed while a memory state is holding. Selects are untouched.
  always_comb begin
    ctl_out = ctl;
    if (hold) begin
      ctl_out.ir_write  = 1'b0;
      ctl_out.pc_update = 1'b0;
      ctl_out.mem_write = 1'b0;
      ctl_out.retire    = 1'b0;
    end
    if (!reset) begin
      ctl_out.ir_write  = 1'b0;
      ctl_out.pc_update = 1'b0;
      ctl_out.reg_write = 1'b0;
      ctl_out.mem_write = 1'b0;
      ctl_out.branch    = 1'b0;
      ctl_out.retire    = 1'b0;
      ctl_out.trap      = 1'b0;
    end
  end

  assign bus.AdrSrc        = ctl_out.adr_src;
  assign bus.IRWrite       = ctl_out.ir_write;
  assign bus.PCUpdate      = ctl_out.pc_update;
  assign bus.RegWrite      = ctl_out.reg_write;
  assign bus.MemWrite      = ctl_out.mem_write;
  assign bus.Branch        = ctl_out.branch;
  assign bus.ALUSrcA       = ctl_out.src_a;
  assign bus.ALUSrcB       = ctl_out.src_b;
  assign bus.ALUOp         = ctl_out.alu_op;
  assign bus.ResultSrc     = ctl_out.result_src;
  assign bus.FSMState      = state;
  assign bus.instr_retired = ctl_out.retire;
  assign bus.illegal_instr = ctl_out.trap;

  control_fsm_retire_ctr #(.W(RETIRE_CNT_W)) u_retire (
    .clk   (clk),
    .clr_n (reset),
    .inc   (ctl_out.retire),
    .count (bus.retire_count)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. Two instances:
//   dut_a: RETIRE_CNT_W=4, TRAP_HALT=1 (sequencing, wrap, abort, halting trap)
//   dut_b: RETIRE_CNT_W=32, TRAP_HALT=0 (one-cycle trap then refetch)
// The stimulus pushes one expected entry per cycle; the monitor pops and
// compares at the falling edge.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctl;   // {AdrSrc,IRWrite,PCUpdate,RegWrite,MemWrite,Branch,A,B,ALUOp,Res}
    logic        ill;
    logic        ret;
    logic [31:0] cnt;
  } ent_t;

  localparam logic [14:0] EN_MASK    = 15'b0_11111_00_00_000_00;
  localparam logic [14:0] STALL_MASK = 15'b0_11010_00_00_000_00;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, JAL = 7'b1101111, BRANCH = 7'b1100011,
                         LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111,
                         BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic [6:0] op_a = '0, op_b = '0;
  logic       mr_a = 1'b1, mr_b = 1'b1;
  logic       b_on = 1'b0;
  logic [31:0] cnt_a = '0, cnt_b = '0;
  int         n_tests = 0, n_fail = 0;
  ent_t       qa[$], qb[$];

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(4))  ifa ();
  multicycle_control_fsm_if #(.CNT_W(32)) ifb ();
  assign ifa.opcode = op_a;
  assign ifa.mem_ready = mr_a;
  assign ifb.opcode = op_b;
  assign ifb.mem_ready = mr_b;

  multicycle_control_fsm #(.RETIRE_CNT_W(4), .TRAP_HALT(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.master));
  multicycle_control_fsm #(.RETIRE_CNT_W(32), .TRAP_HALT(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.master));

  // Hand-written per-state controls.
  function automatic logic [14:0] tbl(input logic [3:0] st);
    case (st)
      4'd0:  return 15'b0_1_1_0_0_0_00_10_000_10;
      4'd1:  return 15'b0_0_0_0_0_0_01_01_000_00;
      4'd2:  return 15'b0_0_0_0_0_0_10_01_000_00;
      4'd3:  return 15'b1_0_0_0_0_0_00_00_000_00;
      4'd4:  return 15'b0_0_0_1_0_0_00_00_000_01;
      4'd5:  return 15'b1_0_0_0_1_0_00_00_000_00;
      4'd6:  return 15'b0_0_0_0_0_0_10_00_010_00;
      4'd7:  return 15'b0_0_0_0_0_0_10_01_011_00;
      4'd8:  return 15'b0_0_0_1_0_0_00_00_000_00;
      4'd9:  return 15'b0_0_1_0_0_0_01_10_000_00;
      4'd10: return 15'b0_0_0_0_0_1_10_00_100_00;
      4'd11: return 15'b0_0_0_1_0_0_00_00_000_11;
      4'd12: return 15'b0_0_0_0_0_0_01_01_000_00;
      4'd13: return 15'b0_0_1_0_0_0_10_01_000_10;
      4'd14: return 15'b0_0_0_1_0_0_01_10_000_10;
      default: return 15'b0;
    endcase
  endfunction

  function automatic ent_t mk(input logic [3:0] st, input logic rn, input logic mr,
                              input logic [31:0] cnt);
    ent_t e;
    e.st  = st;
    e.ctl = tbl(st);
    e.ill = (st == 4'd15);
    e.ret = (st == 4'd4 || st == 4'd5 || st == 4'd8 || st == 4'd10 ||
             st == 4'd11 || st == 4'd14);
    e.cnt = cnt;
`ifdef CONTROL_FSM_MEM_STALL_EN
    if (!mr && (st == 4'd0 || st == 4'd3 || st == 4'd5)) begin
      e.ctl = e.ctl & ~STALL_MASK;
      e.ret = 1'b0;
    end
`else
    if (mr === 1'bx) e.ret = 1'b0;
`endif
    if (!rn) begin
      e.ctl = e.ctl & ~EN_MASK;
      e.ill = 1'b0;
      e.ret = 1'b0;
      e.cnt = '0;
    end
    return e;
  endfunction

  // Expected contents of the current cycle, then advance to just after the next edge.
  task automatic tick(input logic [3:0] sa, input logic [3:0] sb);
    ent_t e;
    e = mk(sa, rst_a, mr_a, cnt_a);
    qa.push_back(e);
    cnt_a = !rst_a ? 32'd0 : (e.ret ? ((cnt_a + 32'd1) & 32'hF) : cnt_a);
    if (b_on) begin
      e = mk(sb, rst_b, mr_b, cnt_b);
      qb.push_back(e);
      cnt_b = !rst_b ? 32'd0 : (e.ret ? cnt_b + 32'd1 : cnt_b);
    end
    @(posedge clk); #1;
  endtask

  // Run n cycles on one DUT with a nibble-packed expected state list.
  task automatic run(input bit on_b, input logic [6:0] op, input int n, input logic [23:0] seq);
    if (on_b) op_b = op; else op_a = op;
    for (int i = 0; i < n; i++) begin
      if (on_b) tick(4'd0, seq[i*4 +: 4]);
      else      tick(seq[i*4 +: 4], 4'd0);
    end
  endtask

  task automatic chk(input string name, input ent_t e, input ent_t o);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t state got %0d want %0d ctl got %b want %b ill %b/%b ret %b/%b cnt got %0d want %0d",
               name, $time, o.st, e.st, o.ctl, e.ctl, o.ill, e.ill, o.ret, e.ret, o.cnt, e.cnt);
    end
  endtask

  // Monitor: compare whatever the stimulus has queued for this cycle.
  initial begin
    ent_t e, o;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        o = '{st: ifa.FSMState,
              ctl: {ifa.AdrSrc, ifa.IRWrite, ifa.PCUpdate, ifa.RegWrite, ifa.MemWrite,
                    ifa.Branch, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp, ifa.ResultSrc},
              ill: ifa.illegal_instr, ret: ifa.instr_retired, cnt: 32'(ifa.retire_count)};
        chk("dut_a", e, o);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        o = '{st: ifb.FSMState,
              ctl: {ifb.AdrSrc, ifb.IRWrite, ifb.PCUpdate, ifb.RegWrite, ifb.MemWrite,
                    ifb.Branch, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp, ifb.ResultSrc},
              ill: ifb.illegal_instr, ret: ifb.instr_retired, cnt: ifb.retire_count};
        chk("dut_b", e, o);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    // reset: FETCH selects, enables forced low
    tick(4'd0, 4'd0);
    tick(4'd0, 4'd0);
    rst_a = 1'b1;
    run(0, RTYPE,  4, 24'h008610);
`ifndef CONTROL_FSM_MEM_STALL_EN
    // mem_ready is ignored in this build: no holds
    mr_a = 1'b0;
    run(0, LOAD,   5, 24'h043210);
    mr_a = 1'b1;
`endif
    run(0, LOAD,   5, 24'h043210);
    run(0, STORE,  4, 24'h005210);
    run(0, ITYPE,  4, 24'h008710);
    run(0, JAL,    4, 24'h008910);
    run(0, AUIPC,  4, 24'h008C10);
    run(0, JALR,   4, 24'h00ED10);
    run(0, BRANCH, 3, 24'h000A10);
    // enough LUIs to carry the 4-bit count through 15 -> 0
    for (int k = 0; k < 9; k++) run(0, LUI, 3, 24'h000B10);
`ifdef CONTROL_FSM_MEM_STALL_EN
    // FETCH held 3 cycles, then one IRWrite/PCUpdate cycle
    op_a = RTYPE;
    mr_a = 1'b0;
    tick(4'd0, 4'd0); tick(4'd0, 4'd0); tick(4'd0, 4'd0);
    mr_a = 1'b1;
    run(0, RTYPE, 4, 24'h008610);
    // MEMWRITE held 2 cycles, MemWrite/retire only on completion
    run(0, STORE, 3, 24'h000210);
    mr_a = 1'b0;
    tick(4'd5, 4'd0); tick(4'd5, 4'd0);
    mr_a = 1'b1;
    tick(4'd5, 4'd0);
`endif
    // reset lands while in MEMWRITE: everything drops at once
    run(0, STORE, 3, 24'h000210);
    rst_a = 1'b0;
    tick(4'd0, 4'd0);
    rst_a = 1'b1;
    // illegal opcode: halting trap
    run(0, BAD, 3, 24'h000F10);
    for (int k = 0; k < 6; k++) tick(4'd15, 4'd0);
    rst_a = 1'b0;
    // non-halting trap on the second instance
    b_on = 1'b1;
    tick(4'd0, 4'd0);
    rst_b = 1'b1;
    run(1, BAD, 6, 24'hF10F10);
    run(1, LUI, 4, 24'h000B10);
    #10;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d/%0d entries left, want 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised main controller for the multi-cycle RV32I datapath. It extends the base fetch/decode FSM with several additions:
- LUI, AUIPC and JALR sequences, plus all branch opcodes.
- An illegal-opcode trap state.
- A retired-instruction pulse and counter.
- An optional memory-ready stall handshake.

It sits between the instruction register (opcode field) and the datapath muxes and enables. The ALU decoder consumes its `ALUOp`.

## Interface
- `RETIRE_CNT_W`, 32: width of `retire_count`.
- `TRAP_HALT`, 1: 1 = TRAP is terminal until reset; 0 = TRAP lasts one cycle, then FETCH.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instruction opcode, valid from DECODE onward.
- `mem_ready`  in  1  memory access completes this cycle (used only with stall macro).
- `AdrSrc`  out  1  0 = PC, 1 = Result.
- `IRWrite`, `PCUpdate`, `RegWrite`, `MemWrite`, `Branch`  out  1 each  datapath enables.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 reg A.
- `ALUSrcB`  out  2  00 reg B, 01 ImmExt, 10 const 4.
- `ALUOp`  out  3  ADD / SUB / RTYPE / ITYPE / BRANCH code.
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `FSMState`  out  4  current state encoding.
- `instr_retired`  out  1  one-cycle pulse on the last state of each instruction.
- `illegal_instr`  out  1  high while in TRAP.
- `retire_count`  out  RETIRE_CNT_W  retired instructions; wraps modulo 2^W.

## Operation
- Moore FSM: all outputs decode from the state register. Any signal not listed for a state is 0 / 00 / ADD.
- Per-state outputs and next state:
  - FETCH(0): IRWrite, PCUpdate, AdrSrc=0, A=00, B=10, ADD, ResultSrc=10 → DECODE.
  - DECODE(1): A=01, B=01, ADD. Next state by opcode:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BRANCH
    - 0110111 → LUI
    - 0010111 → AUIPC
    - 1100111 → JALR
    - any other → TRAP
  - MEMADR(2): A=10, B=01, ADD → MEMREAD for loads, MEMWRITE for stores.
  - MEMREAD(3): AdrSrc=1, ResultSrc=00 → MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite; retire → FETCH.
  - MEMWRITE(5): AdrSrc=1, ResultSrc=00, MemWrite; retire → FETCH.
  - EXECR(6): A=10, B=00, RTYPE → ALUWB.
  - EXECI(7): A=10, B=01, ITYPE → ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite; retire → FETCH.
  - JAL(9): A=01, B=10, ADD, ResultSrc=00, PCUpdate → ALUWB.
  - BRANCH(10): A=10, B=00, BRANCH, ResultSrc=00, Branch; retire → FETCH.
  - LUI(11): ResultSrc=11, RegWrite; retire → FETCH.
  - AUIPC(12): A=01, B=01, ADD → ALUWB.
  - JALR(13): A=10, B=01, ADD, ResultSrc=10, PCUpdate → JALRWB.
  - JALRWB(14): A=01, B=10, ADD, ResultSrc=10, RegWrite; retire → FETCH.
  - TRAP(15): illegal_instr; stays in TRAP if TRAP_HALT=1, else → FETCH. TRAP never retires.
- `instr_retired` is asserted in every state marked "retire" above. `retire_count` increments on the same clock edge.

## Timing
- While `reset` is low: state=FETCH, `retire_count`=0, and IRWrite/PCUpdate/RegWrite/MemWrite/Branch/instr_retired/illegal_instr are forced 0. Mux selects show FETCH values.
- The first rising edge after reset deassertion performs the first fetch.
- Latencies without stalls:
  - 3 cycles: branch, LUI.
  - 4 cycles: R-type, I-type, JAL, AUIPC, JALR, store.
  - 5 cycles: load.
- A reset assertion mid-instruction aborts immediately. No partial write enable may be asserted after `reset` falls.
- `retire_count` at all ones plus a retire wraps to 0.

## Configuration
- `CONTROL_FSM_MEM_STALL_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold while `mem_ready`=0.
  - IRWrite, PCUpdate and MemWrite assert only in the cycle `mem_ready`=1, as does MEMWRITE's retire.
  - AdrSrc and mux selects stay stable while holding.
- Undefined: `mem_ready` is ignored and every memory state takes one cycle.

## Structure
- Shared package `control_fsm_pkg`:
  - state enum (4-bit, encodings above)
  - opcode constants
  - ALUOp codes: ADD=000, SUB=001, RTYPE=010, ITYPE=011, BRANCH=100
  - ALUSrcA, ALUSrcB and ResultSrc select constants
- Sub-module `control_fsm_retire_ctr`: parametrised wrapping counter with increment enable and async active-low clear.

## Test plan
- Release reset, opcode=0110011 → FSMState 0,1,6,8,0. RegWrite=1 only in state 8. One retire pulse; retire_count=1.
- opcode=0000011, then 0100011 → loads traverse 0,1,2,3,4; stores traverse 0,1,2,5. MemWrite=1 only in state 5. retire_count +2.
- opcode=1100111 → 0,1,13,14,0. PCUpdate in 13 with ResultSrc=10. RegWrite in 14 with A=01, B=10.
- opcode=0110111 → 0,1,11 with ResultSrc=11 and RegWrite. opcode=1111111 → TRAP(15) with illegal_instr=1; with TRAP_HALT=1 it stays 15 for 5+ cycles, and with TRAP_HALT=0 it returns to 0 after one cycle.
- Stall macro on, `mem_ready`=0 for 3 cycles in FETCH → FSMState stays 0 and IRWrite/PCUpdate stay 0. Then `mem_ready`=1 → a single IRWrite+PCUpdate cycle, then DECODE.
- Assert reset in MEMWRITE, and separately start with RETIRE_CNT_W=4 at count 15:
  - Reset in MEMWRITE → MemWrite drops the same cycle, state=0, count=0.
  - Count 15 plus a retire → count wraps to 0.
